branch_predictor: RTL and testbench

Parametrised branch target buffer with per-entry saturating direction counters, for the five-stage pipelined datapath. The IF stage queries it with the current PC and gets a predicted next PC in the same cycle. The EX stage writes back each resolved branch/jump outcome, which replaces static fall-through with speculative fetch. It also keeps branch and mispredict statistics for the testbench and for performance counters.

---
 rtl/diaosi_types_pkg.sv | 34 +++
 rtl/bp_sat_counter.sv | 20 ++
 rtl/branch_predictor.sv | 126 ++++++++++++
 tb/tb_branch_predictor.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/diaosi_types_pkg.sv
// Shared types and constants for the branch target buffer.
// Entry fields are sized for the widest legal configuration; narrower ones zero-fill.
package diaosi_types_pkg;

  localparam int unsigned TAG_MAX_W = 29;
  localparam int unsigned CTR_MAX_W = 4;

  // Left-aligned weakly-taken pattern; the module shifts it down to CTR_W bits.
  localparam logic [CTR_MAX_W-1:0] CTR_WEAK_TAKEN_DIAOSI = 4'b1000;
  localparam logic [31:0]          STAT_MAX_DIAOSI       = '1;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [29:0]          target;
    logic [CTR_MAX_W-1:0] ctr;
  } btb_entry_t;

  typedef enum logic [1:0] {
    UPD_NONE,
    UPD_TRAIN,
    UPD_ALLOC,
    UPD_FLUSH
  } upd_action_e;

  function automatic int unsigned idx_width(input int unsigned entries);
    return $clog2(entries);
  endfunction

  function automatic int unsigned tag_width(input int unsigned entries);
    return 30 - idx_width(entries);
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Saturating up/down counter next-value logic for the BTB direction counters.
module bp_sat_counter #(
  parameter int unsigned CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CTR_W-1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (inc_i && !dec_i && (ctr_i != '1)) begin
      ctr_o = ctr_i + CTR_W'(1);
    end else if (dec_i && !inc_i && (ctr_i != '0)) begin
      ctr_o = ctr_i - CTR_W'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters
// and saturating branch/mispredict statistics.
module branch_predictor
  import diaosi_types_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned CTR_W   = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] pc_i,
  output logic        hit_o,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  input  logic        flush_i,
  input  logic        upd_en_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_target_i,
  input  logic        upd_mispred_i,
  output logic [31:0] br_count_o,
  output logic [31:0] mispred_count_o
);

  localparam int unsigned IDX_W = idx_width(ENTRIES);
  localparam int unsigned TAG_W = tag_width(ENTRIES);
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(CTR_WEAK_TAKEN_DIAOSI >> (CTR_MAX_W - CTR_W));

  btb_entry_t btb_q [ENTRIES];

  logic [31:0]          br_count_q;
  logic [31:0]          mispred_count_q;

  logic [IDX_W-1:0]     rd_idx;
  logic [TAG_MAX_W-1:0] rd_tag;
  logic [IDX_W-1:0]     up_idx;
  logic [TAG_MAX_W-1:0] up_tag;
  logic                 up_hit;
  logic [CTR_W-1:0]     ctr_next;
  upd_action_e          action;
  logic                 unused_addr_lsbs;

  assign unused_addr_lsbs = ^{pc_i[1:0], upd_pc_i[1:0], upd_target_i[1:0]};

  // Lookup: purely combinational, sees only the registered table (no bypass).
  assign rd_idx = pc_i[IDX_W+1:2];
  assign rd_tag = TAG_MAX_W'(pc_i[31:IDX_W+2]);

  assign hit_o         = btb_q[rd_idx].valid && (btb_q[rd_idx].tag == rd_tag);
  assign pred_taken_o  = hit_o && btb_q[rd_idx].ctr[CTR_W-1];
  assign pred_target_o = pred_taken_o ? {btb_q[rd_idx].target, 2'b00} : (pc_i + 32'd4);

  assign up_idx = upd_pc_i[IDX_W+1:2];
  assign up_tag = TAG_MAX_W'(upd_pc_i[31:IDX_W+2]);
  assign up_hit = btb_q[up_idx].valid && (btb_q[up_idx].tag == up_tag);

  bp_sat_counter #(
    .CTR_W (CTR_W)
  ) u_sat_counter (
    .ctr_i (btb_q[up_idx].ctr[CTR_W-1:0]),
    .inc_i (upd_taken_i),
    .dec_i (!upd_taken_i),
    .ctr_o (ctr_next)
  );

  always_comb begin
    action = UPD_NONE;
    if (flush_i) begin
      action = UPD_FLUSH;
    end else if (upd_en_i) begin
      if (up_hit) begin
        action = UPD_TRAIN;
      end else if (upd_taken_i) begin
        action = UPD_ALLOC;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        btb_q[IDX_W'(i)] <= '0;
      end
    end else begin
      case (action)
        UPD_FLUSH: begin
          for (int unsigned i = 0; i < ENTRIES; i++) begin
            btb_q[IDX_W'(i)].valid <= 1'b0;
          end
        end
        UPD_TRAIN: begin
          btb_q[up_idx].ctr <= CTR_MAX_W'(ctr_next);
          if (upd_taken_i) begin
            btb_q[up_idx].target <= upd_target_i[31:2];
          end
        end
        UPD_ALLOC: begin
          btb_q[up_idx] <= '{valid:  1'b1,
                             tag:    up_tag,
                             target: upd_target_i[31:2],
                             ctr:    CTR_MAX_W'(CTR_WEAK)};
        end
        default: ;
      endcase
    end
  end

  // Statistics update even when a flush drops the table write.
  always_ff @(posedge CLK) begin
    if (RST) begin
      br_count_q      <= '0;
      mispred_count_q <= '0;
    end else if (upd_en_i) begin
      if (br_count_q != STAT_MAX_DIAOSI) begin
        br_count_q <= br_count_q + 32'd1;
      end
      if (upd_mispred_i && (mispred_count_q != STAT_MAX_DIAOSI)) begin
        mispred_count_q <= mispred_count_q + 32'd1;
      end
    end
  end

  assign br_count_o      = br_count_q;
  assign mispred_count_o = mispred_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (ENTRIES=16, CTR_W=2).
module tb_branch_predictor;

  logic        CLK;
  logic        RST;
  logic [31:0] pc_i;
  logic        hit_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        flush_i;
  logic        upd_en_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic [31:0] upd_target_i;
  logic        upd_mispred_i;
  logic [31:0] br_count_o;
  logic [31:0] mispred_count_o;

  int unsigned checks;
  int unsigned fails;
  logic [31:0] exp_br;
  logic [31:0] exp_mis;

  branch_predictor #(
    .ENTRIES (16),
    .CTR_W   (2)
  ) dut (
    .CLK             (CLK),
    .RST             (RST),
    .pc_i            (pc_i),
    .hit_o           (hit_o),
    .pred_taken_o    (pred_taken_o),
    .pred_target_o   (pred_target_o),
    .flush_i         (flush_i),
    .upd_en_i        (upd_en_i),
    .upd_pc_i        (upd_pc_i),
    .upd_taken_i     (upd_taken_i),
    .upd_target_i    (upd_target_i),
    .upd_mispred_i   (upd_mispred_i),
    .br_count_o      (br_count_o),
    .mispred_count_o (mispred_count_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic do_upd(input logic [31:0] pc, input logic taken,
                        input logic [31:0] tgt, input logic mis);
    upd_en_i      = 1'b1;
    upd_pc_i      = pc;
    upd_taken_i   = taken;
    upd_target_i  = tgt;
    upd_mispred_i = mis;
    tick();
    upd_en_i      = 1'b0;
    upd_mispred_i = 1'b0;
    if (exp_br != 32'hFFFF_FFFF) exp_br = exp_br + 32'd1;
    if (mis && (exp_mis != 32'hFFFF_FFFF)) exp_mis = exp_mis + 32'd1;
  endtask

  task automatic look(input logic [31:0] pc);
    pc_i = pc;
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    exp_br = '0;
    exp_mis = '0;
    look(32'h40);
    checks++; if (hit_o !== 1'b0) begin fails++; $display("FAIL rst_hit got=%0h exp=0", hit_o); end
    checks++; if (pred_taken_o !== 1'b0) begin fails++; $display("FAIL rst_taken got=%0h exp=0", pred_taken_o); end
    checks++; if (pred_target_o !== 32'h44) begin fails++; $display("FAIL rst_target got=%h exp=00000044", pred_target_o); end
    checks++; if (br_count_o !== 32'h0) begin fails++; $display("FAIL rst_br got=%h exp=0", br_count_o); end
    checks++; if (mispred_count_o !== 32'h0) begin fails++; $display("FAIL rst_mis got=%h exp=0", mispred_count_o); end
  endtask

  task automatic test_allocate();
    do_upd(32'h40, 1'b1, 32'h100, 1'b1);
    look(32'h40);
    checks++; if (hit_o !== 1'b1) begin fails++; $display("FAIL alloc_hit got=%0h exp=1", hit_o); end
    checks++; if (pred_taken_o !== 1'b1) begin fails++; $display("FAIL alloc_taken got=%0h exp=1", pred_taken_o); end
    checks++; if (pred_target_o !== 32'h100) begin fails++; $display("FAIL alloc_target got=%h exp=00000100", pred_target_o); end
    checks++; if (br_count_o !== 32'd1) begin fails++; $display("FAIL alloc_br got=%h exp=1", br_count_o); end
  endtask

  task automatic test_counter();
    do_upd(32'h40, 1'b0, 32'h0, 1'b1);            // ctr 2->1
    look(32'h40);
    checks++; if (hit_o !== 1'b1) begin fails++; $display("FAIL nt1_hit got=%0h exp=1", hit_o); end
    checks++; if (pred_taken_o !== 1'b0) begin fails++; $display("FAIL nt1_taken got=%0h exp=0", pred_taken_o); end
    checks++; if (pred_target_o !== 32'h44) begin fails++; $display("FAIL nt1_target got=%h exp=00000044", pred_target_o); end
    do_upd(32'h40, 1'b0, 32'h0, 1'b0);            // ctr 1->0
    do_upd(32'h40, 1'b0, 32'h0, 1'b0);            // ctr stays 0
    look(32'h40);
    checks++; if (hit_o !== 1'b1) begin fails++; $display("FAIL nt3_hit got=%0h exp=1", hit_o); end
    checks++; if (pred_taken_o !== 1'b0) begin fails++; $display("FAIL nt3_taken got=%0h exp=0", pred_taken_o); end
    do_upd(32'h40, 1'b1, 32'h120, 1'b1);          // ctr 0->1
    look(32'h40);
    checks++; if (pred_taken_o !== 1'b0) begin fails++; $display("FAIL floor_taken got=%0h exp=0", pred_taken_o); end
    do_upd(32'h40, 1'b1, 32'h120, 1'b1);          // ctr 1->2
    look(32'h40);
    checks++; if (pred_target_o !== 32'h120) begin fails++; $display("FAIL retarget got=%h exp=00000120", pred_target_o); end
    do_upd(32'h40, 1'b1, 32'h120, 1'b0);          // ctr 2->3
    do_upd(32'h40, 1'b1, 32'h120, 1'b0);          // ctr stays 3
    do_upd(32'h40, 1'b0, 32'h0, 1'b1);            // ctr 3->2
    look(32'h40);
    checks++; if (pred_taken_o !== 1'b1) begin fails++; $display("FAIL ceil_taken got=%0h exp=1", pred_taken_o); end
    checks++; if (pred_target_o !== 32'h120) begin fails++; $display("FAIL nt_keep_target got=%h exp=00000120", pred_target_o); end
    do_upd(32'h48, 1'b0, 32'h500, 1'b0);          // miss, not taken: no allocation
    look(32'h48);
    checks++; if (hit_o !== 1'b0) begin fails++; $display("FAIL nt_miss_hit got=%0h exp=0", hit_o); end
    checks++; if (pred_target_o !== 32'h4C) begin fails++; $display("FAIL nt_miss_target got=%h exp=0000004c", pred_target_o); end
    checks++; if (br_count_o !== exp_br) begin fails++; $display("FAIL ctr_br got=%h exp=%h", br_count_o, exp_br); end
    checks++; if (mispred_count_o !== exp_mis) begin fails++; $display("FAIL ctr_mis got=%h exp=%h", mispred_count_o, exp_mis); end
  endtask

  task automatic test_alias();
    do_upd(32'h440, 1'b1, 32'h200, 1'b1);
    look(32'h40);
    checks++; if (hit_o !== 1'b0) begin fails++; $display("FAIL alias_old_hit got=%0h exp=0", hit_o); end
    look(32'h440);
    checks++; if (hit_o !== 1'b1) begin fails++; $display("FAIL alias_new_hit got=%0h exp=1", hit_o); end
    checks++; if (pred_target_o !== 32'h200) begin fails++; $display("FAIL alias_target got=%h exp=00000200", pred_target_o); end
  endtask

  task automatic test_same_cycle();
    pc_i          = 32'h80;
    upd_en_i      = 1'b1;
    upd_pc_i      = 32'h80;
    upd_taken_i   = 1'b1;
    upd_target_i  = 32'h300;
    upd_mispred_i = 1'b0;
    #1;
    checks++; if (hit_o !== 1'b0) begin fails++; $display("FAIL same_pre_hit got=%0h exp=0", hit_o); end
    checks++; if (pred_target_o !== 32'h84) begin fails++; $display("FAIL same_pre_target got=%h exp=00000084", pred_target_o); end
    tick();
    upd_en_i = 1'b0;
    exp_br = exp_br + 32'd1;
    #1;
    checks++; if (hit_o !== 1'b1) begin fails++; $display("FAIL same_post_hit got=%0h exp=1", hit_o); end
    checks++; if (pred_target_o !== 32'h300) begin fails++; $display("FAIL same_post_target got=%h exp=00000300", pred_target_o); end
    flush_i = 1'b1;
    do_upd(32'h84, 1'b1, 32'h400, 1'b1);
    flush_i = 1'b0;
    look(32'h84);
    checks++; if (hit_o !== 1'b0) begin fails++; $display("FAIL flush_upd_hit got=%0h exp=0", hit_o); end
    look(32'h80);
    checks++; if (hit_o !== 1'b0) begin fails++; $display("FAIL flush_80_hit got=%0h exp=0", hit_o); end
    look(32'h440);
    checks++; if (hit_o !== 1'b0) begin fails++; $display("FAIL flush_440_hit got=%0h exp=0", hit_o); end
    checks++; if (br_count_o !== exp_br) begin fails++; $display("FAIL flush_br got=%h exp=%h", br_count_o, exp_br); end
    checks++; if (mispred_count_o !== exp_mis) begin fails++; $display("FAIL flush_mis got=%h exp=%h", mispred_count_o, exp_mis); end
  endtask

  task automatic test_mid_reset();
    do_upd(32'h440, 1'b1, 32'h200, 1'b0);
    look(32'h440);
    checks++; if (hit_o !== 1'b1) begin fails++; $display("FAIL mrst_pre_hit got=%0h exp=1", hit_o); end
    RST           = 1'b1;
    upd_en_i      = 1'b1;
    upd_pc_i      = 32'h80;
    upd_taken_i   = 1'b1;
    upd_target_i  = 32'h300;
    upd_mispred_i = 1'b1;
    tick();
    RST           = 1'b0;
    upd_en_i      = 1'b0;
    upd_mispred_i = 1'b0;
    exp_br  = '0;
    exp_mis = '0;
    look(32'h440);
    checks++; if (hit_o !== 1'b0) begin fails++; $display("FAIL mrst_440_hit got=%0h exp=0", hit_o); end
    look(32'h80);
    checks++; if (hit_o !== 1'b0) begin fails++; $display("FAIL mrst_80_hit got=%0h exp=0", hit_o); end
    checks++; if (br_count_o !== 32'h0) begin fails++; $display("FAIL mrst_br got=%h exp=0", br_count_o); end
    checks++; if (mispred_count_o !== 32'h0) begin fails++; $display("FAIL mrst_mis got=%h exp=0", mispred_count_o); end
  endtask

  task automatic test_saturate();
    force dut.br_count_q      = 32'hFFFF_FFFE;
    force dut.mispred_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.br_count_q;
    release dut.mispred_count_q;
    #1;
    exp_br  = 32'hFFFF_FFFE;
    exp_mis = 32'hFFFF_FFFE;
    checks++; if (br_count_o !== exp_br) begin fails++; $display("FAIL sat_preload_br got=%h exp=%h", br_count_o, exp_br); end
    do_upd(32'h40, 1'b1, 32'h100, 1'b1);
    checks++; if (br_count_o !== 32'hFFFF_FFFF) begin fails++; $display("FAIL sat_step_br got=%h exp=ffffffff", br_count_o); end
    checks++; if (mispred_count_o !== 32'hFFFF_FFFF) begin fails++; $display("FAIL sat_step_mis got=%h exp=ffffffff", mispred_count_o); end
    do_upd(32'h40, 1'b1, 32'h100, 1'b1);
    do_upd(32'h40, 1'b1, 32'h100, 1'b1);
    checks++; if (br_count_o !== 32'hFFFF_FFFF) begin fails++; $display("FAIL sat_br got=%h exp=ffffffff", br_count_o); end
    checks++; if (mispred_count_o !== 32'hFFFF_FFFF) begin fails++; $display("FAIL sat_mis got=%h exp=ffffffff", mispred_count_o); end
  endtask

  initial begin
    checks        = 0;
    fails         = 0;
    exp_br        = '0;
    exp_mis       = '0;
    RST           = 1'b1;
    pc_i          = '0;
    flush_i       = 1'b0;
    upd_en_i      = 1'b0;
    upd_pc_i      = '0;
    upd_taken_i   = 1'b0;
    upd_target_i  = '0;
    upd_mispred_i = 1'b0;
    test_reset();
    test_allocate();
    test_counter();
    test_alias();
    test_same_cycle();
    test_mid_reset();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
